// File: rtl/cp0_interrupt_unit_if.sv
// Datapath <-> coprocessor-0 bundle: interrupt sources, mfc0/mtc0/eret access, EPC and take signal.
// irq_id exists only when CP0_IRQ_ID_EN is defined.
interface cp0_interrupt_unit_if #(
  parameter int EXT_IRQS = 7
);
  logic                TimerInterrupt;
  logic [EXT_IRQS-1:0] ext_irq;
  logic [4:0]          regnum;
  logic [31:0]         wr_data;
  logic                MTC0;
  logic                ERET;
  logic [31:0]         pc;
  logic [31:0]         rd_data;
  logic [31:0]         EPC;
  logic                TakenInterrupt;
`ifdef CP0_IRQ_ID_EN
  logic [2:0]          irq_id;
`endif

  // Datapath side: drives the sources and accesses, consumes the results.
  modport master (
    output TimerInterrupt, ext_irq, regnum, wr_data, MTC0, ERET, pc,
`ifdef CP0_IRQ_ID_EN
    input  irq_id,
`endif
    input  rd_data, EPC, TakenInterrupt
  );

  modport slave (
    input  TimerInterrupt, ext_irq, regnum, wr_data, MTC0, ERET, pc,
`ifdef CP0_IRQ_ID_EN
    output irq_id,
`endif
    output rd_data, EPC, TakenInterrupt
  );
endinterface

// File: rtl/cp0_interrupt_unit.sv
// Coprocessor-0 interrupt unit: Status/Cause/EPC, sticky pending capture, interrupt take and eret.
// Optional macro CP0_IRQ_ID_EN adds irq_id and latches it into Cause.ExcCode on entry.
module cp0_interrupt_unit #(
  parameter int          TIMER_IP  = 7,   // must be >= EXT_IRQS and <= 7
  parameter int          EXT_IRQS  = 7,
  parameter logic [31:0] EPC_RESET = 32'h0
) (
  input  logic                  clock,
  input  logic                  reset,
  cp0_interrupt_unit_if.slave   bus
);

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  logic [7:0]  im;
  logic        exl;
  logic        ie;
  logic [7:0]  ip;
  logic [31:0] epcReg;
  logic [7:0]  srcIrq;
  logic [7:0]  activeIrq;
  logic        takenInterrupt;
  logic [4:0]  excCode;

  // Map the timer and external lines onto the 8-bit IP field.
  for (genvar g = 0; g < 8; g++) begin : g_src
    if (g == TIMER_IP) begin : g_timer
      assign srcIrq[g] = bus.TimerInterrupt;
    end else if (g < EXT_IRQS) begin : g_ext
      assign srcIrq[g] = bus.ext_irq[g];
    end else begin : g_none
      assign srcIrq[g] = 1'b0;
    end
  end

  assign activeIrq      = ip & im;
  assign takenInterrupt = ie & ~exl & (|activeIrq);

`ifdef CP0_IRQ_ID_EN
  logic [2:0] irqId;

  always_comb begin
    irqId = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (activeIrq[i]) irqId = 3'(i);
    end
  end

  assign bus.irq_id = irqId;

  always_ff @(posedge clock) begin
    if (reset) begin
      excCode <= 5'd0;
    end else if (takenInterrupt) begin
      excCode <= {2'b00, irqId};
    end else if (bus.MTC0 && bus.regnum == REG_CAUSE) begin
      excCode <= 5'd0;
    end
  end
`else
  assign excCode = 5'd0;
`endif

  always_ff @(posedge clock) begin
    // NOTE: non-blocking throughout; a later assignment in this block overrides an earlier one
    // on the same edge, which is how ERET beats an mtc0 Status write on EXL.
    if (reset) begin
      im     <= 8'h00;
      exl    <= 1'b0;
      ie     <= 1'b0;
      ip     <= 8'h00;
      epcReg <= EPC_RESET;
    end else begin
      ip <= ip | srcIrq;
      if (takenInterrupt) begin
        // The decoding instruction is squashed, so its mtc0/eret must not commit.
        exl    <= 1'b1;
        epcReg <= bus.pc;
      end else begin
        if (bus.MTC0) begin
          unique case (bus.regnum)
            REG_STATUS: begin
              im  <= bus.wr_data[15:8];
              exl <= bus.wr_data[1];
              ie  <= bus.wr_data[0];
            end
            // A live source line re-sets its bit even while software clears it.
            REG_CAUSE: ip     <= bus.wr_data[15:8] | srcIrq;
            REG_EPC:   epcReg <= bus.wr_data;
            default:   ;
          endcase
        end
        if (bus.ERET) exl <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.rd_data = 32'h0;
    unique case (bus.regnum)
      REG_STATUS: bus.rd_data = {16'h0, im, 6'b0, exl, ie};
      REG_CAUSE:  bus.rd_data = {16'h0, ip, 1'b0, excCode, 2'b00};
      REG_EPC:    bus.rd_data = epcReg;
      default:    bus.rd_data = 32'h0;
    endcase
  end

  assign bus.EPC            = epcReg;
  assign bus.TakenInterrupt = takenInterrupt;

endmodule

// File: tb/tb_cp0_interrupt_unit.sv
// Scoreboard bench for cp0_interrupt_unit: directed vectors push expectations, a negedge monitor checks them.
// Define CP0_IRQ_ID_EN to also exercise irq_id and ExcCode latching.
module tb_cp0_interrupt_unit;

  localparam int EXT_IRQS = 7;

`ifdef CP0_IRQ_ID_EN
  localparam logic [31:0] EC7 = 32'h0000_001C;
`else
  localparam logic [31:0] EC7 = 32'h0;
`endif

  typedef struct {
    string       name;
    logic [31:0] expRd;
    logic        expTaken;
    logic [31:0] expEpc;
    logic        chkId;
    logic [2:0]  expId;
  } expect_t;

  logic clock;
  logic reset;
  cp0_interrupt_unit_if #(.EXT_IRQS(EXT_IRQS)) bus ();

  cp0_interrupt_unit #(
    .TIMER_IP (7),
    .EXT_IRQS (EXT_IRQS),
    .EPC_RESET(32'h0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  expect_t expQ[$];
  logic    vecValid;
  int      nVectors;
  int      nChecks;
  int      nFails;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string vec, input string field, input logic [31:0] act,
                       input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s.%s: got %h, expected %h", vec, field, act, exp);
    end
  endtask

  // Monitor: every cycle a vector is presented, compare against the oldest expectation.
  always @(negedge clock) begin
    if (vecValid) begin
      if (expQ.size() == 0) begin
        nFails++;
        $display("FAIL scoreboard: got output with empty queue, expected an entry");
      end else begin
        expect_t e;
        e = expQ.pop_front();
        nVectors++;
        check(e.name, "rd_data", bus.rd_data, e.expRd);
        check(e.name, "TakenInterrupt", {31'b0, bus.TakenInterrupt}, {31'b0, e.expTaken});
        check(e.name, "EPC", bus.EPC, e.expEpc);
`ifdef CP0_IRQ_ID_EN
        if (e.chkId) check(e.name, "irq_id", {29'b0, bus.irq_id}, {29'b0, e.expId});
`endif
      end
    end
  end

  task automatic applyVec(input string name, input logic rst, input logic [4:0] rn,
                          input logic [31:0] wr, input logic mtc0, input logic eret,
                          input logic tmr, input logic [6:0] ext, input logic [31:0] pcv,
                          input logic [31:0] expRd, input logic expTaken,
                          input logic [31:0] expEpc, input logic chkId = 1'b0,
                          input logic [2:0] expId = 3'd0);
    expect_t e;
    @(posedge clock);
    #1;
    reset              = rst;
    bus.regnum         = rn;
    bus.wr_data        = wr;
    bus.MTC0           = mtc0;
    bus.ERET           = eret;
    bus.TimerInterrupt = tmr;
    bus.ext_irq        = ext;
    bus.pc             = pcv;
    e.name     = name;
    e.expRd    = expRd;
    e.expTaken = expTaken;
    e.expEpc   = expEpc;
    e.chkId    = chkId;
    e.expId    = expId;
    expQ.push_back(e);
    vecValid = 1'b1;
  endtask

  initial begin
    nVectors = 0;
    nChecks  = 0;
    nFails   = 0;
    vecValid = 1'b0;
    reset    = 1'b1;
    bus.regnum = 5'd0; bus.wr_data = 32'h0; bus.MTC0 = 1'b0; bus.ERET = 1'b0;
    bus.TimerInterrupt = 1'b0; bus.ext_irq = '0; bus.pc = 32'h0;
    repeat (2) @(posedge clock);

    //        name          rst rn     wr_data        mtc0 eret tmr ext    pc             expRd              tk  expEpc
    applyVec("idle0",       0, 5'd12, 32'h0,         0,   0,   0,  7'h00, 32'h0,         32'h0,             0, 32'h0);
    applyVec("idle1",       0, 5'd13, 32'h0,         0,   0,   0,  7'h00, 32'h0,         32'h0,             0, 32'h0);
    applyVec("idle2",       0, 5'd14, 32'h0,         0,   0,   0,  7'h00, 32'h0,         32'h0,             0, 32'h0);
    applyVec("idle3",       0, 5'd12, 32'h0,         0,   0,   0,  7'h00, 32'h0,         32'h0,             0, 32'h0);
    applyVec("idle4",       0, 5'd13, 32'h0,         0,   0,   0,  7'h00, 32'h0,         32'h0,             0, 32'h0);
    // Enable timer, pulse it, take the interrupt.
    applyVec("wrStatus",    0, 5'd12, 32'h8001,      1,   0,   0,  7'h00, 32'h0,         32'h0,             0, 32'h0);
    applyVec("tmrPulse",    0, 5'd12, 32'h0,         0,   0,   1,  7'h00, 32'h0,         32'h8001,          0, 32'h0);
    applyVec("take1",       0, 5'd13, 32'h0,         0,   0,   0,  7'h00, 32'h00400020,  32'h8000,          1, 32'h0);
    applyVec("inHandler",   0, 5'd12, 32'h0,         0,   0,   0,  7'h00, 32'h0,         32'h8003,          0, 32'h00400020);
    // Software clear inside handler, then eret.
    applyVec("clrCause",    0, 5'd13, 32'h0,         1,   0,   0,  7'h00, 32'h0,         32'h8000 | EC7,    0, 32'h00400020);
    applyVec("eret1",       0, 5'd13, 32'h0,         0,   1,   0,  7'h00, 32'h0,         32'h0,             0, 32'h00400020);
    applyVec("afterEret",   0, 5'd12, 32'h0,         0,   0,   0,  7'h00, 32'h0,         32'h8001,          0, 32'h00400020);
    // Clear racing a live timer line: set wins.
    applyVec("clrVsSet",    0, 5'd13, 32'h0,         1,   0,   1,  7'h00, 32'h0,         32'h0,             0, 32'h00400020);
    // Interrupt coincident with mtc0 Status=0: write squashed.
    applyVec("takeSquash",  0, 5'd12, 32'h0,         1,   0,   0,  7'h00, 32'h00400100,  32'h8001,          1, 32'h00400020);
    applyVec("squashed",    0, 5'd12, 32'h0,         0,   0,   0,  7'h00, 32'h0,         32'h8003,          0, 32'h00400100);
    // mtc0 Status(EXL=1, IM=0) with ERET: ERET wins on EXL.
    applyVec("eretMtc0",    0, 5'd12, 32'h0003,      1,   1,   0,  7'h00, 32'h0,         32'h8003,          0, 32'h00400100);
    applyVec("maskedPend",  0, 5'd12, 32'h0,         0,   0,   0,  7'h00, 32'h0,         32'h0001,          0, 32'h00400100);
    applyVec("extPulse",    0, 5'd13, 32'h0,         0,   0,   0,  7'h01, 32'h0,         32'h8000 | EC7,    0, 32'h00400100);
    applyVec("unmask",      0, 5'd12, 32'h8001,      1,   0,   0,  7'h00, 32'h0,         32'h0001,          0, 32'h00400100);
    applyVec("take2",       0, 5'd13, 32'h0,         0,   0,   0,  7'h00, 32'h00400200,  32'h8100 | EC7,    1, 32'h00400100);
    applyVec("wrEpc",       0, 5'd14, 32'h00001234,  1,   0,   0,  7'h00, 32'h0,         32'h00400200,      0, 32'h00400200);
    applyVec("badRegWr",    0, 5'd14, 32'hFFFFFFFF,  0,   0,   0,  7'h00, 32'h0,         32'h00001234,      0, 32'h00001234);
    applyVec("badReg",      0, 5'd5,  32'hFFFFFFFF,  1,   0,   0,  7'h00, 32'h0,         32'h0,             0, 32'h00001234);
    // Reset while EXL=1 and IP nonzero; sources on that edge are ignored.
    applyVec("midReset",    1, 5'd5,  32'h0,         0,   0,   1,  7'h7F, 32'h0,         32'h0,             0, 32'h00001234);
    applyVec("postRstSt",   0, 5'd12, 32'h0,         0,   0,   0,  7'h00, 32'h0,         32'h0,             0, 32'h0);
    applyVec("postRstCa",   0, 5'd13, 32'h0,         0,   0,   0,  7'h00, 32'h0,         32'h0,             0, 32'h0);
`ifdef CP0_IRQ_ID_EN
    applyVec("idSetup",     0, 5'd12, 32'hFF01,      1,   0,   1,  7'h04, 32'h0,         32'h0,             0, 32'h0,         1, 3'd0);
    applyVec("idTake",      0, 5'd13, 32'h0,         0,   0,   0,  7'h00, 32'h00000300,  32'h8400,          1, 32'h0,         1, 3'd7);
    applyVec("idExc",       0, 5'd13, 32'h0,         0,   0,   0,  7'h00, 32'h0,         32'h841C,          0, 32'h00000300,  1, 3'd7);
    applyVec("idMask",      0, 5'd12, 32'h0402,      1,   0,   0,  7'h00, 32'h0,         32'hFF03,          0, 32'h00000300,  1, 3'd7);
    applyVec("idLow",       0, 5'd13, 32'h0,         0,   0,   0,  7'h00, 32'h0,         32'h841C,          0, 32'h00000300,  1, 3'd2);
    applyVec("idClrExc",    0, 5'd13, 32'h8400,      1,   0,   0,  7'h00, 32'h0,         32'h841C,          0, 32'h00000300,  1, 3'd2);
    applyVec("idCleared",   0, 5'd13, 32'h0,         0,   0,   0,  7'h00, 32'h0,         32'h8400,          0, 32'h00000300,  1, 3'd2);
`endif

    @(posedge clock);
    #1;
    vecValid = 1'b0;
    bus.MTC0 = 1'b0; bus.ERET = 1'b0; bus.TimerInterrupt = 1'b0; bus.ext_irq = '0;
    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clock);
    if (expQ.size() != 0) begin
      nFails++;
      $display("FAIL drain: got %0d pending expectations, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFails);
    $finish;
  end

endmodule
